// File: rtl/angle_req_arbiter_if.sv
// angle_req_arbiter_if: requester and engine signals of the angle arbiter
//   master : arbiter side; takes req/req_angle/fault_clr/angle_done, drives
//            done/fault to requesters and angle_update/target_angle/abort_angle
//            to the angle_to_pwm engine
//   slave  : requester/engine side, the mirror image
interface angle_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ANGLE_W = 12
);
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*ANGLE_W-1:0] req_angle;
   logic [NUM_REQ-1:0]         fault_clr;
   logic [NUM_REQ-1:0]         done;
   logic [NUM_REQ-1:0]         fault;
   logic                       angle_done;
   logic                       angle_update;
   logic [ANGLE_W-1:0]         target_angle;
   logic                       abort_angle;
   modport master (
      input  req, req_angle, fault_clr, angle_done,
      output done, fault, angle_update, target_angle, abort_angle
   );
   modport slave (
      output req, req_angle, fault_clr, angle_done,
      input  done, fault, angle_update, target_angle, abort_angle
   );
endinterface

// File: rtl/angle_req_arbiter.sv
// angle_req_arbiter: round-robin scheduler of one shared angle_to_pwm engine
//   clock, reset   : clock, synchronous active-high reset
//   enable         : low blocks new grants and aborts an active move
//   timeout_cycles : move timeout in clocks, 0 disables it
//   bus            : requester and engine handshake (master side)
//   busy           : high whenever not idle
//   active_id      : granted or last-granted requester
module angle_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ANGLE_W = 12,
   parameter int TMO_W   = 20
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [TMO_W-1:0]   timeout_cycles,
   angle_req_arbiter_if.master bus,
   output logic               busy,
   output logic [1:0]         active_id
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, COMPLETE} state_t;
   state_t state, state_nxt;
   logic [1:0] last_id, win_id, idx;
   logic [TMO_W-1:0] timer;
   logic [NUM_REQ-1:0] elig;
   logic win_vld, cancel, tmo_hit, tmo_abort;
   assign elig = bus.req & ~bus.fault;
   assign cancel = !bus.req[active_id] || !enable;
   assign tmo_hit = timeout_cycles != '0 && timer == timeout_cycles - TMO_W'(1);
   // scan from the farthest candidate down so the nearest one after last_id wins
   always_comb begin
      win_id = '0;
      win_vld = 1'b0;
      idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = 2'((int'(last_id) + k) % NUM_REQ);
         if (elig[idx]) begin
            win_id = idx;
            win_vld = 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      bus.angle_update = state == ISSUE;
      bus.abort_angle = state == ABORT;
      bus.done = state == COMPLETE ? (NUM_REQ'(1) << active_id) : '0;
      busy = state != IDLE;
      case (state)
         IDLE:    state_nxt = enable && win_vld ? ISSUE : IDLE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = bus.angle_done ? COMPLETE : (cancel || tmo_hit) ? ABORT : WAIT;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.target_angle <= '0;
         active_id <= '0;
         last_id <= 2'(NUM_REQ - 1);
         timer <= '0;
         tmo_abort <= 1'b0;
         bus.fault <= '0;
      end else begin
         if (state == IDLE && state_nxt == ISSUE) begin
            bus.target_angle <= bus.req_angle[win_id*ANGLE_W +: ANGLE_W];
            active_id <= win_id;
            last_id <= win_id;
         end
         timer <= state == ISSUE ? '0 : (state == WAIT && timer != '1) ? timer + 1'b1 : timer;
         // remember why we abort: only a timeout (not done, not cancel) faults the requester
         if (state == WAIT)
            tmo_abort <= !bus.angle_done && !cancel && tmo_hit;
         // a timeout set wins over a same-cycle clear
         bus.fault <= (bus.fault & ~bus.fault_clr) | ((state == ABORT && tmo_abort) ? (NUM_REQ'(1) << active_id) : '0);
      end
   end
endmodule
